// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, byte type and FIFO sizing helpers.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    typedef logic [7:0] uart_byte_t;

    // Occupancy/pointer width: one extra bit so that a full FIFO is distinguishable from empty.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_w(FIFO_DEPTH);

endpackage

// File: rtl/uart_rise_det.sv
// Single-bit rising-edge detector; RST_VAL sets the assumed previous level out of reset.
module uart_rise_det
    import uart_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures a byte on each rising in_done, drains over valid/ready.
// Optional saturating drop counter enabled by `define UART_RX_FIFO_DROPCNT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
    parameter int DATA_W = uart_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_done,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [7:0]                drop_count
);

    localparam int PTR_W  = cnt_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic wr_en;
    logic drop;
    logic is_empty;
    logic is_full;

    uart_rise_det #(
        .RST_VAL (1'b1)
    ) u_done_det (
        .clk  (clk),
        .rst  (rst),
        .d    (in_done),
        .rise (push)
    );

    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A pop frees the slot at the same edge, so a push into a full FIFO is still accepted.
    assign pop   = ~is_empty & out_ready;
    assign wr_en = push & (~is_full | pop);
    assign drop  = push & is_full & ~pop;

    // NOTE: the storage array has no reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop) begin
            if (overflow_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (overflow_clr) begin
            drop_count <= '0;
        end
    end
`else
    assign drop_count = '0;
`endif

    assign out_valid = ~is_empty;
    assign out_data  = out_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;
    assign count     = wr_ptr - rd_ptr;
    assign full      = is_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16); honours UART_RX_FIFO_DROPCNT_EN.
module tb_uart_rx_fifo;
    import uart_pkg::*;

`ifdef UART_RX_FIFO_DROPCNT_EN
    localparam logic [7:0] DROP_ONE = 8'd1;
`else
    localparam logic [7:0] DROP_ONE = 8'd0;
`endif

    logic       clk;
    logic       rst;
    uart_byte_t in_data;
    logic       in_done;
    uart_byte_t out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       overflow_clr;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;
    uart_byte_t q[$];

    uart_rx_fifo #(
        .DEPTH  (16),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_done      (in_done),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input uart_byte_t b);
        in_data = b;
        in_done = 1'b1;
        step();
        in_done = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_done      = 1'b1;
        in_data      = 8'h00;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        step();
        step();
        check("rst_count",     count,      0);
        check("rst_valid",     out_valid,  0);
        check("rst_data",      out_data,   0);
        check("rst_full",      full,       0);
        check("rst_overflow",  overflow,   0);
        check("rst_dropcnt",   drop_count, 0);

        // in_done already high out of reset must not push.
        rst = 1'b0;
        step();
        step();
        check("held_done_count", count,     0);
        check("held_done_valid", out_valid, 0);

        in_done = 1'b0;
        step();
        push_byte(8'h5A);
        check("first_valid", out_valid, 1);
        check("first_data",  out_data,  8'h5A);
        check("first_count", count,     1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("first_pop_valid", out_valid, 0);
        check("first_pop_count", count,     0);

        // Fill to DEPTH.
        for (int i = 1; i <= 16; i++) push_byte(uart_byte_t'(i));
        check("fill_full",  full,     1);
        check("fill_count", count,    16);
        check("fill_head",  out_data, 8'h01);

        // 17th push with no pop is dropped.
        push_byte(8'hAA);
        check("ovf_set",     overflow,   1);
        check("ovf_dropcnt", drop_count, DROP_ONE);
        check("ovf_count",   count,      16);
        check("ovf_head",    out_data,   8'h01);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr",         overflow,   0);
        check("ovf_clr_dropcnt", drop_count, 0);

        // Drain in order; 0xAA must not appear.
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_data_%0d", i), out_data, i);
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_count", count,     0);
        check("drain_full",  full,      0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 16; i++) push_byte(uart_byte_t'(i));
        in_data   = 8'hBB;
        in_done   = 1'b1;
        out_ready = 1'b1;
        step();
        in_done   = 1'b0;
        out_ready = 1'b0;
        check("pp_full_count", count,    16);
        check("pp_full_full",  full,     1);
        check("pp_full_head",  out_data, 8'h02);
        check("pp_full_ovf",   overflow, 0);
        step();
        for (int i = 2; i <= 17; i++) begin
            check($sformatf("pp_drain_%0d", i), out_data, (i == 17) ? 32'hBB : i);
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("pp_drain_count", count, 0);

        // in_done held high for 5 cycles yields a single push.
        in_data = 8'h33;
        in_done = 1'b1;
        repeat (5) step();
        in_done = 1'b0;
        step();
        check("held5_count", count,    1);
        check("held5_data",  out_data, 8'h33);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("held5_pop_count", count, 0);

        // 40 pushes with pops starting after 8, wrapping the pointers.
        for (int i = 0; i < 40; i++) begin
            in_data   = uart_byte_t'(8'h40 + i);
            in_done   = 1'b1;
            out_ready = (i >= 8);
            if (out_ready) begin
                check($sformatf("wrap_pop_%0d", i), out_data, q[0]);
                void'(q.pop_front());
            end
            q.push_back(uart_byte_t'(8'h40 + i));
            step();
            in_done   = 1'b0;
            out_ready = 1'b0;
            step();
        end
        check("wrap_count", count, q.size());
        while (q.size() > 0) begin
            check("wrap_drain", out_data, q[0]);
            void'(q.pop_front());
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("wrap_end_count", count,     0);
        check("wrap_end_valid", out_valid, 0);

        // Asynchronous reset with 7 entries, checked before any clock edge.
        for (int i = 0; i < 7; i++) push_byte(uart_byte_t'(8'h70 + i));
        check("pre_rst_count", count,    7);
        check("pre_rst_head",  out_data, 8'h70);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count,     0);
        check("arst_valid", out_valid, 0);
        check("arst_data",  out_data,  0);
        check("arst_full",  full,      0);
        rst = 1'b0;
        step();
        push_byte(8'hC3);
        check("post_rst_count", count,    1);
        check("post_rst_data",  out_data, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
